// File: rtl/instr_encoder_pkg.sv
// ============================================================================
// Module   : instr_encoder_pkg
// Purpose  : Shared immediate-format constants, source typedef and field masks
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_encoder_pkg;

  typedef logic [1:0] imm_src_t;

  localparam imm_src_t IMM_I = 2'b00;
  localparam imm_src_t IMM_S = 2'b01;
  localparam imm_src_t IMM_B = 2'b10;
  localparam imm_src_t IMM_J = 2'b11;

  // Instruction bits owned by the immediate in each format
  localparam logic [31:0] C_MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] C_MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] C_MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] C_MASK_J = 32'hFFFF_F000;

endpackage

`default_nettype wire

// File: rtl/instr_encoder_imm_pack.sv
// ============================================================================
// Module   : instr_encoder_imm_pack
// Purpose  : Combinational scatter of an immediate into RISC-V I/S/B/J slots
//            plus a flag telling whether the value fits the format.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  imm_src_t    src,
  output logic [31:0] word,
  output logic        in_range
);

  logic [31:0] w_field;
  logic [31:0] w_mask;

  always_comb begin
    w_field  = 32'd0;
    w_mask   = C_MASK_I;
    in_range = 1'b0;
    case (src)
      IMM_I: begin
        w_field  = {imm[11:0], 20'd0};
        w_mask   = C_MASK_I;
        in_range = (&imm[31:11]) | ~(|imm[31:11]);
      end
      IMM_S: begin
        w_field  = {imm[11:5], 13'd0, imm[4:0], 7'd0};
        w_mask   = C_MASK_S;
        in_range = (&imm[31:11]) | ~(|imm[31:11]);
      end
      IMM_B: begin
        w_field  = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
        w_mask   = C_MASK_B;
        in_range = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      end
      default: begin
        w_field  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
        w_mask   = C_MASK_J;
        in_range = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      end
    endcase
  end

  assign word = (base & ~w_mask) | w_field;

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs immediates into instruction words and streams them out with
//            sequential instruction-memory addresses. Build macro
//            IMM_RANGE_CHECK_EN enables dropping of unencodable requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_base,
  input  logic [31:0] in_imm,
  input  logic [1:0]  in_src,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] count
);

  logic [31:0] w_word;
  logic        w_in_range;
  logic        w_drop;
  logic        w_accept;
  logic        w_emit;
  logic        w_out_hs;

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_addr;
  logic [15:0] r_count;

  instr_encoder_imm_pack u_imm_pack (
    .base     (in_base),
    .imm      (in_imm),
    .src      (in_src),
    .word     (w_word),
    .in_range (w_in_range)
  );

`ifdef IMM_RANGE_CHECK_EN
  assign w_drop = ~w_in_range;
`else
  assign w_drop = w_in_range & 1'b0;
`endif

  assign in_ready = ~restart & (~r_valid | out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_emit   = w_accept & ~w_drop;
  assign w_out_hs = r_valid & out_ready;

  // out_addr is the counter itself: it advances past a word once it is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= 32'd0;
      r_addr  <= BASE_ADDR;
      r_count <= 16'd0;
    end else if (restart) begin
      r_valid <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_count <= 16'd0;
    end else begin
      if (w_out_hs) begin
        r_addr  <= r_addr + ADDR_STEP;
        r_count <= r_count + 16'd1;
      end
      if (w_emit) begin
        r_valid <= 1'b1;
        r_instr <= w_word;
      end else if (w_out_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (restart) begin
      r_err <= 1'b0;
    end else if (w_accept && w_drop) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_addr  = r_addr;
  assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Directed self-checking bench for instr_encoder (honours the
//            IMM_RANGE_CHECK_EN build macro when choosing expectations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic [1:0]  in_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] count;

  int n_checks;
  int n_fail;

  instr_encoder #(
    .BASE_ADDR (32'h0000_0000),
    .ADDR_STEP (32'd4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_imm    (in_imm),
    .in_src    (in_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] b, input logic [31:0] i, input logic [1:0] s);
    in_valid = 1'b1;
    in_base  = b;
    in_imm   = i;
    in_src   = s;
  endtask

  logic [31:0] exp_addr;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    restart   = 1'b0;
    in_valid  = 1'b0;
    in_base   = 32'd0;
    in_imm    = 32'd0;
    in_src    = 2'b00;
    out_ready = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_addr",  out_addr, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // I format, sign-extended -1
    drive(32'h0000_0093, 32'hFFFF_FFFF, 2'b00);
    #1;
    check("i_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("i_valid", {31'd0, out_valid}, 32'd1);
    check("i_instr", out_instr, 32'hFFF0_0093);
    check("i_addr",  out_addr, 32'd0);
    out_ready = 1'b1;
    step();
    check("i_hs_valid", {31'd0, out_valid}, 32'd0);
    check("i_hs_count", {16'd0, count}, 32'd1);
    check("i_hs_addr",  out_addr, 32'd4);

    restart = 1'b1;
    #1;
    check("rs_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    restart = 1'b0;
    check("rs_addr",  out_addr, 32'd0);
    check("rs_count", {16'd0, count}, 32'd0);

    // S then B back to back with the consumer always ready
    drive(32'h0020_A023, 32'd8, 2'b01);
    step();
    drive(32'h0000_0063, 32'hFFFF_FFFC, 2'b10);
    check("s_valid", {31'd0, out_valid}, 32'd1);
    check("s_instr", out_instr, 32'h0020_A423);
    check("s_addr",  out_addr, 32'd0);
    check("s_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("b_valid", {31'd0, out_valid}, 32'd1);
    check("b_instr", out_instr, 32'hFE00_0EE3);
    check("b_addr",  out_addr, 32'd4);
    step();
    check("sb_done_valid", {31'd0, out_valid}, 32'd0);
    check("sb_count", {16'd0, count}, 32'd2);
    check("sb_addr",  out_addr, 32'd8);

    // J with a 3-cycle consumer stall
    out_ready = 1'b0;
    drive(32'h0000_00EF, 32'h0000_0800, 2'b11);
    step();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("j_instr",    out_instr, 32'h0010_00EF);
      check("j_addr",     out_addr, 32'd8);
      check("j_valid",    {31'd0, out_valid}, 32'd1);
      check("j_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("j_count", {16'd0, count}, 32'd3);
    check("j_addr_after", out_addr, 32'd12);

    // I immediate of 0x800 does not fit 12 signed bits
    drive(32'h0000_0013, 32'h0000_0800, 2'b00);
    step();
    in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    check("rng_valid", {31'd0, out_valid}, 32'd0);
    check("rng_err",   {31'd0, err}, 32'd1);
    check("rng_addr",  out_addr, 32'd12);
    check("rng_count", {16'd0, count}, 32'd3);
    exp_addr = 32'd12;
`else
    check("trunc_valid", {31'd0, out_valid}, 32'd1);
    check("trunc_instr", out_instr, 32'h8000_0013);
    check("trunc_err",   {31'd0, err}, 32'd0);
    check("trunc_addr",  out_addr, 32'd12);
    step();
    exp_addr = 32'd16;
`endif
    drive(32'h0000_0013, 32'd5, 2'b00);
    step();
    in_valid = 1'b0;
    check("next_valid", {31'd0, out_valid}, 32'd1);
    check("next_instr", out_instr, 32'h0050_0013);
    check("next_addr",  out_addr, exp_addr);

    // restart coinciding with an output handshake and a pending request
    drive(32'h0000_0013, 32'd1, 2'b00);
    restart = 1'b1;
    #1;
    check("rs_hs_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    restart  = 1'b0;
    in_valid = 1'b0;
    check("rs_hs_valid", {31'd0, out_valid}, 32'd0);
    check("rs_hs_addr",  out_addr, 32'd0);
    check("rs_hs_count", {16'd0, count}, 32'd0);
    check("rs_hs_err",   {31'd0, err}, 32'd0);

    // asynchronous reset while a word is stalled
    out_ready = 1'b0;
    drive(32'h0000_0013, 32'd2, 2'b00);
    step();
    in_valid = 1'b0;
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_instr", out_instr, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
